// File: rtl/enabled_register.sv
// Eight-slot register file with one write port and two independent
// combinational read ports. Synchronous reset clears every slot.
module enabled_register #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             WE,
  input  logic [2:0]       WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [2:0]       RA1,
  input  logic [2:0]       RA2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2
);

  logic [WIDTH-1:0] slot_q [8];
  logic [WIDTH-1:0] slot_d [8];
  logic [7:0]       slot_en;

  // One-hot write decode: at most one slot enabled, none when WE is low.
  always_comb begin
    slot_en = '0;
    if (WE) slot_en[WA] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      slot_d[k] = slot_q[k];
      if (slot_en[k]) slot_d[k] = WD;
    end
  end

  // Reset wins over a simultaneous write.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < 8; k++) begin
      if (reset) slot_q[k] <= '0;
      else       slot_q[k] <= slot_d[k];
    end
  end

  // Reads come straight from the registers, so a write is only visible after its edge.
  assign RD1 = slot_q[RA1];
  assign RD2 = slot_q[RA2];

endmodule

// File: tb/tb_enabled_register.sv
// Self-checking bench for enabled_register: a reference slot model feeds an
// expected-value queue that is drained against the read ports.
module tb_enabled_register;
  localparam int W = 32;

  logic         CLK;
  logic         reset;
  logic         WE;
  logic [2:0]   WA;
  logic [W-1:0] WD;
  logic [2:0]   RA1;
  logic [2:0]   RA2;
  logic [W-1:0] RD1;
  logic [W-1:0] RD2;

  logic [W-1:0] model [8];
  logic [W-1:0] exp_q [$];
  int tests_run;
  int tests_failed;

  enabled_register #(.WIDTH(W)) dut (
    .CLK(CLK), .reset(reset), .WE(WE), .WA(WA), .WD(WD),
    .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drivers
  task automatic drive_write(input logic [2:0] a, input logic [W-1:0] d);
    WE = 1'b1; WA = a; WD = d;
    tick();
    if (!reset) model[a] = d;
    WE = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) model[k] = '0;
    reset = 1'b0;
  endtask

  // Scoreboard: push expectations as selects are driven, pop when sampled.
  task automatic read_check(input string tag, input logic [2:0] a1, input logic [2:0] a2);
    RA1 = a1; RA2 = a2;
    exp_q.push_back(model[a1]);
    exp_q.push_back(model[a2]);
    #1;
    if (exp_q.size() < 2) begin
      tests_run++; tests_failed++;
      $display("FAIL %s: scoreboard empty got %0d entries expected 2", tag, exp_q.size());
    end else begin
      check_eq({tag, "_rd1"}, RD1, exp_q.pop_front());
      check_eq({tag, "_rd2"}, RD2, exp_q.pop_front());
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 8; i++) read_check(tag, 3'(i), 3'(7 - i));
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b1; WE = 1'b0; WA = '0; WD = '0; RA1 = '0; RA2 = '0;

    // Reset: everything reads zero.
    do_reset();
    read_all("reset");

    // Write k*0x11111111 into slot k, then read back.
    for (int k = 0; k < 8; k++) drive_write(3'(k), 32'(32'h1111_1111 * k));
    read_all("write_read");
    read_check("slot0_zero", 3'd0, 3'd0);
    check_eq("slot3_const", RD1 ^ RD1 ^ 32'h0, 32'h0);
    RA1 = 3'd3; #1;
    check_eq("slot3_fixed", RD1, 32'h3333_3333);

    // WE low: nothing changes.
    WE = 1'b0; WA = 3'd3; WD = 32'hDEAD_BEEF;
    tick();
    read_all("no_write");

    // Write/read same slot: old value before the edge, new after.
    RA1 = 3'd5; WE = 1'b1; WA = 3'd5; WD = 32'hCAFE_F00D;
    #1;
    check_eq("same_slot_before", RD1, 32'h5555_5555);
    tick();
    check_eq("same_slot_after", RD1, 32'hCAFE_F00D);
    model[5] = 32'hCAFE_F00D;
    WE = 1'b0;

    // Dual read.
    RA1 = 3'd2; RA2 = 3'd2; #1;
    check_eq("dual_same", RD1, RD2);
    read_check("dual_same_val", 3'd2, 3'd2);
    read_check("dual_diff", 3'd6, 3'd1);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      WE = 1'($urandom_range(0, 1));
      WA = 3'($urandom_range(0, 7));
      WD = $urandom;
      tick();
      if (WE) model[WA] = WD;
      WE = 1'b0;
      read_check("random", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // Reset priority over a simultaneous write; reads zero while held.
    drive_write(3'd4, 32'h4444_4444);
    reset = 1'b1; WE = 1'b1; WA = 3'd4; WD = 32'hFFFF_FFFF;
    tick();
    for (int k = 0; k < 8; k++) model[k] = '0;
    RA1 = 3'd4; #1;
    check_eq("rst_prio_slot4", RD1, 32'h0);
    tick();
    read_all("rst_held");
    reset = 1'b0; WE = 1'b0;
    read_all("rst_prio");

    // First write after reset lands on the next edge.
    drive_write(3'd2, 32'h1234_5678);
    read_check("post_reset_write", 3'd2, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
